// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store engine.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  localparam int TIMEOUT_DEF = 255;

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_bad = 1'b0;
      SZ_HALF: is_bad = lane[0];
      SZ_WORD: is_bad = |lane;
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: lane_rep = {4{wd[7:0]}};
      SZ_HALF: lane_rep = {2{wd[15:0]}};
      default: lane_rep = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{b[7] & ~uns}}, b};
      SZ_HALF: data = {{16{h[15] & ~uns}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs one request/grant/response bus access per
// memory instruction and stalls the pipeline until it completes.
//
// state | meaning
// IDLE  | waiting for a memory instruction; bad accesses skip straight to DONE
// REQ   | mem_req_o held until granted or timed out
// RESP  | load granted, waiting for mem_rvalid_i or timeout
// DONE  | one-cycle completion; pipeline advances, done_o/err_o valid
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  Size_i,
  input  logic        Unsigned_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic [31:0] Read_Data_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q, lane_q;
  logic [29:0]   waddr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q, rd_q, fmt_data;
  logic          access, bad, tmo;

  assign access      = valid_i & (MemRead_i | MemWrite_i);
  assign bad         = is_bad(Size_i, Addr_i[1:0]);
  // >= rather than ==: a load granted on the last REQ cycle enters RESP already expired
  assign tmo         = (cnt_q >= TMO_LAST);
  assign Read_Data_o = rd_q;

  load_formatter u_fmt (
    .rdata (mem_rdata_i),
    .lane  (lane_q),
    .size  (size_q),
    .uns   (uns_q),
    .data  (fmt_data)
  );

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        // gated by reset so every output reads 0 while rst_i is low
        stall_o = access & rst_i;
        if (access) state_d = bad ? DONE : REQ;
      end
      REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {waddr_q, 2'b00};
        mem_be_o    = be_q;
        mem_wdata_o = wdata_q;
        if (mem_gnt_i)  state_d = we_q ? DONE : RESP;
        else if (tmo)   state_d = DONE;
      end
      RESP: begin
        stall_o = 1'b1;
        if (mem_rvalid_i || tmo) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (access) begin
            err_q   <= bad;
            cnt_q   <= '0;
            we_q    <= MemWrite_i;
            uns_q   <= Unsigned_i;
            size_q  <= Size_i;
            lane_q  <= Addr_i[1:0];
            waddr_q <= Addr_i[31:2];
            be_q    <= byte_en(Size_i, Addr_i[1:0]);
            wdata_q <= lane_rep(Size_i, WrData_i);
            if (bad) rd_q <= '0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (!mem_gnt_i && tmo) begin
            rd_q  <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: begin
          cnt_q <= cnt_q + CW'(1);
          if (mem_rvalid_i) begin
            rd_q <= fmt_data;
          end else if (tmo) begin
            rd_q  <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store engine between the EX/MEM pipe register and the MEM/WB pipe register. It takes the MEM-stage control and address, runs a variable-latency request/grant/response transaction on the data-memory bus, and formats load data into Read_Data_o, which feeds MEM/WB Read_Data_i. While a transaction is in flight it holds the pipeline with stall_o. It also handles byte, half and word sizes, misalignment, and bus timeout.

Parameters:
TIMEOUT, 255, max cycles in REQ+RESP before abort; counter width is clog2(TIMEOUT+1).

Ports:
clk_i  in  1  clock
rst_i  in  1  async reset, active-low
valid_i  in  1  MEM-stage instruction valid
MemRead_i  in  1  load
MemWrite_i  in  1  store; MemRead_i and MemWrite_i are never both high
Size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
Unsigned_i  in  1  zero-extend loads (lbu/lhu)
Addr_i  in  32  byte address from ALU_Res
WrData_i  in  32  store data, right-aligned
Read_Data_o  out  32  formatted load data, registered
stall_o  out  1  freeze PC/IF/ID/EX/EX_MEM; insert bubble into MEM/WB
done_o  out  1  access completes this cycle
err_o  out  1  misaligned, illegal size or timeout; valid with done_o
mem_req_o  out  1  bus request
mem_we_o  out  1  write
mem_addr_o  out  32  word-aligned address, {Addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data

Behaviour:
- Reset (async, rst_i=0): state IDLE; all outputs 0; timeout counter 0. mem_req_o drops immediately, including mid-transaction; any outstanding response is ignored.
- access = valid_i & (MemRead_i | MemWrite_i). bad = Size_i==11, or half with Addr[0]=1, or word with Addr[1:0]!=0.
- States:
  - IDLE:
    - access&!bad: register we/addr/be/wdata/size/unsigned, go to REQ.
    - access&bad: Read_Data_o<=0, go to DONE with err latched.
    - !access: stay; Read_Data_o holds.
  - REQ: mem_req_o=1, plus the registered we/addr/be/wdata. On mem_gnt_i: a store goes to DONE; a load goes to RESP. The request is held until granted.
  - RESP: on mem_rvalid_i, Read_Data_o<=formatted data, go to DONE.
  - DONE: done_o=1, err_o=latched err, stall_o=0; the pipeline advances at this edge; go to IDLE.
- stall_o (combinational) = (IDLE & access) | REQ | RESP. A non-memory instruction passes with zero stall.
- Minimum latency: a store takes 3 cycles (IDLE, REQ with gnt, DONE). A load takes 4 cycles (IDLE, REQ, RESP with rvalid, DONE).
- Lanes are little-endian; lane = Addr[1:0].
  - be: byte 0001<<lane; half 0011<<lane; word 1111.
  - wdata: byte {4{WrData[7:0]}}; half {2{WrData[15:0]}}; word as-is.
  - Load: select the lane from rdata, then sign-extend, or zero-extend if Unsigned_i.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/RESP. When it reaches TIMEOUT: Read_Data_o<=0, err latched, go to DONE, mem_req_o dropped. A gnt or rvalid arriving in the same cycle as the timeout wins over the timeout.
- mem_rvalid_i outside RESP is ignored. mem_gnt_i outside REQ is ignored.
- done_o and err_o are registered-state decodes: high for exactly one cycle per access.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL
  - state enum IDLE/REQ/RESP/DONE
  - TIMEOUT default
- One natural sub-module, load_formatter: purely combinational lane select plus extension. mem_access_unit instantiates it on mem_rdata_i.

Test Plan:
1. lw to 0x100; gnt after 2 cycles, rvalid 1 cycle later with rdata 0xDEADBEEF -> mem_addr_o=0x100, be=1111, stall_o high for 4 cycles, done_o pulse, Read_Data_o=0xDEADBEEF, err_o=0.
2. lb and lbu to 0x103 with rdata 0x80FF1234 -> lb gives Read_Data_o=0xFFFFFF80, lbu gives 0x00000080. Then lh to 0x102 -> 0xFFFF80FF.
3. sh WrData 0x0000ABCD to 0x206, gnt immediate -> mem_we_o=1, mem_addr_o=0x204, be=1100, wdata=0xABCDABCD, done_o 2 cycles after entry, no RESP state.
4. lw to 0x102 -> no mem_req_o ever, one stall cycle, done_o=err_o=1, Read_Data_o=0. Repeat with Size_i=11 -> same response.
5. TIMEOUT=4, gnt held low -> mem_req_o drops after 4 cycles, err_o=1 with done_o, Read_Data_o=0. Second case: gnt arrives on the 4th cycle -> normal completion, err_o=0.
6. rst_i low during RESP -> mem_req_o, stall_o, Read_Data_o go 0 immediately. A late rvalid after reset is ignored; the next lw completes normally. Back-to-back sw then lw -> both complete with no lost access.
